fp_arith_unit: RTL and testbench
================================

Name: fp_arith_unit

Overview:
- Multi-cycle IEEE-754 single-precision arithmetic unit. Performs add, subtract, multiply and divide.
- Sits beside the pipeline register file as the FPU execution block.
- Uses a start/done handshake and reports zero, overflow and underflow status.
- Merges the adder, multiplier and divider sub-units behind one op select, driven from a single clock.

Parameters:
- DIV_BITS, 24, number of quotient mantissa bits produced by the divider, one per cycle.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch request; sampled only while busy=0.
- op  input  2  operation: 00 add, 01 subtract (a-b), 10 divide (a/b), 11 multiply.
- a  input  32  operand A, IEEE-754 single.
- b  input  32  operand B, IEEE-754 single.
- result  output  32  IEEE-754 single result; held stable until the next accepted start.
- done  output  1  one-cycle pulse when result and flags are valid.
- busy  output  1  high from the accepted start until the cycle done pulses.
- zero  output  1  result magnitude is zero.
- overflow  output  1  result saturated to infinity.
- underflow  output  1  result flushed to zero from a nonzero exact value.

Behaviour:
- Reset: result=0, done=0, busy=0, zero=0, overflow=0, underflow=0, FSM=IDLE.
  - Reset mid-operation aborts the operation; no done is produced.
- Handshake:
  - start is accepted in IDLE. a, b and op are registered on that edge.
  - start while busy=1 is ignored.
  - done pulses exactly once per accepted start.
  - result and flags update on the same edge done rises.
- FSM: IDLE -> UNPACK -> EXEC -> NORM -> IDLE (done emitted on NORM exit).
  - UNPACK: split sign, exponent and mantissa; insert hidden 1.
  - EXEC length: add/sub 1 cycle, mul 1 cycle, div DIV_BITS+2 cycles.
- Latency, counted from the start edge to the edge where done=1:
  - add/sub: 4.
  - mul: 4.
  - div: DIV_BITS+5 (=29).
- Denormal inputs (exp=0) are treated as signed zero. Denormals are never produced.
- Rounding is round-toward-zero (truncate) for all operations.
- Add/sub:
  - Subtract inverts sign(b).
  - Align the smaller exponent using 3 extra guard bits, which are discarded after normalisation.
  - Add or subtract magnitudes, then normalise left or right.
  - Exact cancellation gives +0 (0x00000000).
- Mul:
  - Sign is the XOR of the operand signs; exponent is ea+eb-127.
  - 24x24 product; normalise by at most one shift.
- Div:
  - Sign is the XOR of the operand signs; exponent is ea-eb+127.
  - Restoring division of the 24-bit mantissas, one quotient bit per cycle. Produce a 25th bit for normalisation, then truncate.
- Exponent range after normalisation:
  - exp>=255: result is ±infinity (0x7F800000 | sign<<31), overflow=1.
  - exp<=0: result is ±0, underflow=1.
- Special operands:
  - Any NaN input, inf-inf (effective), 0*inf, 0/0 or inf/inf gives 0x7FC00000 with all flags 0.
  - Other infinity operands propagate a signed infinity with flags 0.
  - Finite nonzero / 0 gives signed infinity with overflow=1.
  - 0 / nonzero gives signed zero.
- zero=1 whenever result[30:0]==0, including underflow.
- Flags are mutually consistent: overflow and zero are never both 1.

Test Plan:
- Add: a=0x3FC00000, b=0x40100000, op=00, start for 1 cycle -> done on the 4th edge, result=0x40700000, all flags 0.
- Subtract cancel: a=b=0x3F800000, op=01 -> result=0x00000000, zero=1, overflow=0, underflow=0.
- Multiply: a=0x40400000, b=0xC0000000, op=11 -> result=0xC0C00000 after 4 cycles. Then a=0x7F000000, b=0x40000000 -> result=0x7F800000, overflow=1.
- Divide: a=0x3F800000, b=0x40400000, op=10 -> done on the 29th edge, result=0x3EAAAAAA (truncated). Then a=0x40000000, b=0x00000000 -> 0x7F800000, overflow=1.
- Busy and ignored start:
  - During a divide, pulse start with op=00 -> ignored; exactly one done, carrying the divide result.
  - 0x7F800000 - 0x7F800000 -> 0x7FC00000.
- Reset: assert reset 10 cycles into a divide -> next edge busy=0, done=0, result=0. A following add of 0x3FC00000+0x40100000 completes normally with 0x40700000.

Source files
------------

// File: rtl/fp_arith_unit.sv
// Multi-cycle IEEE-754 single-precision add/sub/mul/div unit with a start/done handshake.
// Round-toward-zero; denormal inputs read as signed zero and denormals are never produced.
module fp_arith_unit #(
    parameter int unsigned DIV_BITS = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        zero,
    output logic        overflow,
    output logic        underflow
);
    localparam int unsigned QW = DIV_BITS + 1;
    localparam int unsigned CW = $clog2(DIV_BITS + 2);
    localparam int unsigned RW = 26;
    localparam int unsigned EW = 11;

    localparam logic [1:0]  OP_ADD  = 2'b00;
    localparam logic [1:0]  OP_SUB  = 2'b01;
    localparam logic [1:0]  OP_DIV  = 2'b10;
    localparam logic [1:0]  OP_MUL  = 2'b11;
    localparam logic [30:0] INF_MAG = 31'h7F80_0000;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_EXEC, S_NORM} state_t;

    state_t state_q, state_d;

    logic [31:0]          a_r, b_r;
    logic [1:0]           op_r;
    logic                 sa, sb;
    logic [7:0]           ea, eb;
    logic [23:0]          ma, mb;
    logic                 spc_valid, spc_ovf;
    logic [31:0]          spc_res;
    logic [CW-1:0]        cnt;
    logic [RW-1:0]        rem;
    logic [QW-1:0]        quo;
    logic                 x_sign, x_zero;
    logic signed [EW-1:0] x_exp;
    logic [22:0]          x_mant;

    // Unpack view of the captured operands (b sign already flipped for subtract)
    logic        ua_s, ub_s, ua_nan, ub_nan, ua_inf, ub_inf, ua_zero, ub_zero;
    logic [7:0]  ua_e, ub_e;
    logic [23:0] ua_m, ub_m;

    always_comb begin
        ua_s    = a_r[31];
        ub_s    = b_r[31] ^ (op_r == OP_SUB);
        ua_e    = a_r[30:23];
        ub_e    = b_r[30:23];
        ua_zero = (ua_e == 8'd0);
        ub_zero = (ub_e == 8'd0);
        ua_inf  = (ua_e == 8'hFF) && (a_r[22:0] == 23'd0);
        ub_inf  = (ub_e == 8'hFF) && (b_r[22:0] == 23'd0);
        ua_nan  = (ua_e == 8'hFF) && (a_r[22:0] != 23'd0);
        ub_nan  = (ub_e == 8'hFF) && (b_r[22:0] != 23'd0);
        ua_m    = ua_zero ? 24'd0 : {1'b1, a_r[22:0]};
        ub_m    = ub_zero ? 24'd0 : {1'b1, b_r[22:0]};
    end

    // Special-operand outcomes; these override the arithmetic path at NORM
    logic        spc_valid_n, spc_ovf_n, s_prod;
    logic [31:0] spc_res_n;

    always_comb begin
        spc_valid_n = 1'b0;
        spc_ovf_n   = 1'b0;
        spc_res_n   = '0;
        s_prod      = ua_s ^ ub_s;
        case (op_r)
            OP_ADD, OP_SUB: begin
                if (ua_nan || ub_nan || (ua_inf && ub_inf && (ua_s != ub_s))) begin
                    spc_valid_n = 1'b1;
                    spc_res_n   = QNAN;
                end else if (ua_inf) begin
                    spc_valid_n = 1'b1;
                    spc_res_n   = {ua_s, INF_MAG};
                end else if (ub_inf) begin
                    spc_valid_n = 1'b1;
                    spc_res_n   = {ub_s, INF_MAG};
                end
            end
            OP_MUL: begin
                if (ua_nan || ub_nan || (ua_inf && ub_zero) || (ua_zero && ub_inf)) begin
                    spc_valid_n = 1'b1;
                    spc_res_n   = QNAN;
                end else if (ua_inf || ub_inf) begin
                    spc_valid_n = 1'b1;
                    spc_res_n   = {s_prod, INF_MAG};
                end
            end
            default: begin
                if (ua_nan || ub_nan || (ua_zero && ub_zero) || (ua_inf && ub_inf)) begin
                    spc_valid_n = 1'b1;
                    spc_res_n   = QNAN;
                end else if (ua_inf) begin
                    spc_valid_n = 1'b1;
                    spc_res_n   = {s_prod, INF_MAG};
                end else if (ub_inf) begin
                    spc_valid_n = 1'b1;
                    spc_res_n   = {s_prod, 31'd0};
                end else if (ub_zero) begin
                    spc_valid_n = 1'b1;
                    spc_ovf_n   = 1'b1;
                    spc_res_n   = {s_prod, INF_MAG};
                end
            end
        endcase
    end

    // Add/sub: align with three guard bits, add or subtract, find the leading one
    logic        add_a_big, add_big_s;
    logic [7:0]  add_big_e, add_sml_e, add_shift;
    logic [23:0] add_big_m, add_sml_m;
    logic [27:0] add_ext_big, add_ext_sml, add_sum, add_norm;
    logic [4:0]  add_lead;

    always_comb begin
        add_a_big   = {ea, ma} >= {eb, mb};
        add_big_s   = add_a_big ? sa : sb;
        add_big_e   = add_a_big ? ea : eb;
        add_sml_e   = add_a_big ? eb : ea;
        add_big_m   = add_a_big ? ma : mb;
        add_sml_m   = add_a_big ? mb : ma;
        add_shift   = add_big_e - add_sml_e;
        add_ext_big = {1'b0, add_big_m, 3'b000};
        add_ext_sml = {1'b0, add_sml_m, 3'b000} >> add_shift;
        add_sum     = (sa ^ sb) ? (add_ext_big - add_ext_sml) : (add_ext_big + add_ext_sml);
        add_lead    = '0;
        for (int i = 0; i < 28; i++) begin
            if (add_sum[i]) add_lead = 5'(i);
        end
        add_norm = add_sum << (5'd27 - add_lead);
    end

    logic [47:0] prod;
    assign prod = ma * mb;

    // One restoring-division step per cycle
    logic          div_ge;
    logic [RW-1:0] rem_sub, rem_n;
    logic [QW-1:0] quo_n;

    always_comb begin
        div_ge  = rem >= {2'b00, mb};
        rem_sub = div_ge ? (rem - {2'b00, mb}) : rem;
        rem_n   = rem_sub << 1;
        quo_n   = {quo[QW-2:0], div_ge};
    end

    logic                 x_sign_n, x_zero_n;
    logic signed [EW-1:0] x_exp_n;
    logic [22:0]          x_mant_n;

    always_comb begin
        x_sign_n = 1'b0;
        x_zero_n = 1'b0;
        x_exp_n  = '0;
        x_mant_n = '0;
        case (op_r)
            OP_MUL: begin
                x_sign_n = sa ^ sb;
                x_zero_n = (ma == 24'd0) || (mb == 24'd0);
                x_exp_n  = EW'(ea) + EW'(eb) - EW'(127) + EW'(prod[47]);
                x_mant_n = prod[47] ? prod[46:24] : prod[45:23];
            end
            OP_DIV: begin
                x_sign_n = sa ^ sb;
                x_zero_n = (ma == 24'd0);
                x_exp_n  = EW'(ea) - EW'(eb) + EW'(126) + EW'(quo_n[QW-1]);
                x_mant_n = quo_n[QW-1] ? quo_n[QW-2 -: 23] : quo_n[QW-3 -: 23];
            end
            default: begin
                x_zero_n = (add_sum == 28'd0);
                x_sign_n = x_zero_n ? (sa & sb) : add_big_s;
                x_exp_n  = EW'(add_big_e) + EW'(add_lead) - EW'(26);
                x_mant_n = add_norm[26:4];
            end
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{prod[22:0], add_norm[27], add_norm[3:0], quo[QW-1]};

    // Range check and final packing
    logic [31:0] fin_res;
    logic        fin_ovf, fin_uf;

    always_comb begin
        fin_res = {x_sign, x_exp[7:0], x_mant};
        fin_ovf = 1'b0;
        fin_uf  = 1'b0;
        if (spc_valid) begin
            fin_res = spc_res;
            fin_ovf = spc_ovf;
        end else if (x_zero) begin
            fin_res = {x_sign, 31'd0};
        end else if (x_exp >= 11'sd255) begin
            fin_res = {x_sign, INF_MAG};
            fin_ovf = 1'b1;
        end else if (x_exp <= 11'sd0) begin
            fin_res = {x_sign, 31'd0};
            fin_uf  = 1'b1;
        end
    end

    logic exec_last;
    assign exec_last = (op_r != OP_DIV) || (cnt == CW'(QW));

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_UNPACK;
            S_UNPACK: state_d = S_EXEC;
            S_EXEC:   if (exec_last) state_d = S_NORM;
            S_NORM:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_r <= '0; b_r <= '0; op_r <= '0;
            sa <= 1'b0; sb <= 1'b0; ea <= '0; eb <= '0; ma <= '0; mb <= '0;
            spc_valid <= 1'b0; spc_ovf <= 1'b0; spc_res <= '0;
            cnt <= '0; rem <= '0; quo <= '0;
            x_sign <= 1'b0; x_zero <= 1'b0; x_exp <= '0; x_mant <= '0;
            result <= '0; done <= 1'b0; busy <= 1'b0;
            zero <= 1'b0; overflow <= 1'b0; underflow <= 1'b0;
        end else begin
            done <= (state_q == S_NORM);
            busy <= (state_d != S_IDLE);
            if (state_q == S_IDLE && start) begin
                a_r  <= a;
                b_r  <= b;
                op_r <= op;
            end
            if (state_q == S_UNPACK) begin
                sa <= ua_s; sb <= ub_s; ea <= ua_e; eb <= ub_e; ma <= ua_m; mb <= ub_m;
                spc_valid <= spc_valid_n;
                spc_ovf   <= spc_ovf_n;
                spc_res   <= spc_res_n;
                cnt       <= '0;
            end
            if (state_q == S_EXEC) begin
                cnt <= cnt + CW'(1);
                if (op_r == OP_DIV) begin
                    if (cnt == '0) begin
                        rem <= {2'b00, ma};
                        quo <= '0;
                    end else begin
                        rem <= rem_n;
                        quo <= quo_n;
                    end
                end
                if (exec_last) begin
                    x_sign <= x_sign_n;
                    x_zero <= x_zero_n;
                    x_exp  <= x_exp_n;
                    x_mant <= x_mant_n;
                end
            end
            if (state_q == S_NORM) begin
                result    <= fin_res;
                overflow  <= fin_ovf;
                underflow <= fin_uf;
                zero      <= (fin_res[30:0] == 31'd0);
            end
        end
    end
endmodule

// File: tb/tb_fp_arith_unit.sv
// Directed bench for fp_arith_unit: scoreboard queue of expected results, checked at done.
module tb_fp_arith_unit;
    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  flags;
    } exp_t;

    localparam int LAT_MAX = 60;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [1:0]  op;
    logic [31:0] a, b, result;
    logic        done, busy, zero, overflow, underflow;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    fp_arith_unit #(.DIV_BITS(24)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .result(result), .done(done), .busy(busy), .zero(zero),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Launch one operation, wait (bounded) for done, compare against the scoreboard head
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] er, input logic [2:0] ef,
                          input int lat);
        exp_t e;
        int   n;
        logic got;
        sb_q.push_back({er, ef});
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < LAT_MAX) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                check({tag, " busy"}, 32'(busy), 32'd1);
                start = 1'b0;
            end
            got = done;
        end
        check({tag, " latency"}, 32'(n), 32'(lat));
        e = sb_q.pop_front();
        if (got) begin
            check({tag, " result"}, result, e.res);
            check({tag, " flags zou"}, {29'd0, zero, overflow, underflow}, {29'd0, e.flags});
            check({tag, " busy at done"}, 32'(busy), 32'd0);
            @(posedge clk); #1;
            check({tag, " done pulse"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t        e;
        int          n, dones, first_done;
        logic [31:0] cap_res;
        logic [2:0]  cap_flags;

        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset result", result, 32'd0);
        check("reset flags", {29'd0, zero, overflow, underflow}, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        reset = 1'b0;

        run_op("add",        2'b00, 32'h3FC00000, 32'h40100000, 32'h40700000, 3'b000, 4);
        run_op("sub cancel", 2'b01, 32'h3F800000, 32'h3F800000, 32'h00000000, 3'b100, 4);
        run_op("mul",        2'b11, 32'h40400000, 32'hC0000000, 32'hC0C00000, 3'b000, 4);
        run_op("mul ovf",    2'b11, 32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010, 4);
        run_op("mul unf",    2'b11, 32'h00800000, 32'h00800000, 32'h00000000, 3'b101, 4);
        run_op("add mixed",  2'b00, 32'h40400000, 32'hBF800000, 32'h40000000, 3'b000, 4);
        run_op("sub lshift", 2'b01, 32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 3'b000, 4);
        run_op("add ovf",    2'b00, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b010, 4);
        run_op("inf-inf",    2'b01, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b000, 4);
        run_op("nan add",    2'b00, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b000, 4);
        run_op("inf mul",    2'b11, 32'h7F800000, 32'hC0000000, 32'hFF800000, 3'b000, 4);
        run_op("0*inf",      2'b11, 32'h00000000, 32'h7F800000, 32'h7FC00000, 3'b000, 4);
        run_op("div 1/3",    2'b10, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000, 29);
        run_op("div 6/3",    2'b10, 32'h40C00000, 32'h40400000, 32'h40000000, 3'b000, 29);
        run_op("div -0/2",   2'b10, 32'h80000000, 32'h40000000, 32'h80000000, 3'b100, 29);
        run_op("div 0/0",    2'b10, 32'h00000000, 32'h00000000, 32'h7FC00000, 3'b000, 29);

        // A start pulse during a divide must be ignored
        sb_q.push_back({32'h3EAAAAAA, 3'b000});
        @(negedge clk);
        op = 2'b10; a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        op = 2'b00; a = 32'h3FC00000; b = 32'h40100000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign busy", 32'(busy), 32'd1);
        n = 5;
        dones = 0;
        first_done = 0;
        cap_res = '0;
        cap_flags = 3'b111;
        repeat (40) begin
            @(posedge clk); #1;
            n++;
            if (done) begin
                dones++;
                if (first_done == 0) begin
                    first_done = n;
                    cap_res = result;
                    cap_flags = {zero, overflow, underflow};
                end
            end
        end
        e = sb_q.pop_front();
        check("ign done count", 32'(dones), 32'd1);
        check("ign latency", 32'(first_done), 32'd29);
        check("ign result", cap_res, e.res);
        check("ign flags zou", {29'd0, cap_flags}, {29'd0, e.flags});

        run_op("div 2/0",    2'b10, 32'h40000000, 32'h00000000, 32'h7F800000, 3'b010, 29);

        // Reset ten cycles into a divide aborts it
        @(negedge clk);
        op = 2'b10; a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", result, 32'd0);
        check("rst flags", {29'd0, zero, overflow, underflow}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (35) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("rst no done", 32'(dones), 32'd0);
        run_op("add after rst", 2'b00, 32'h3FC00000, 32'h40100000, 32'h40700000, 3'b000, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
